// File: rtl/cjtag_scan_sequencer.sv
// ---------------------------------------------------------------------------
// cjtag_scan_sequencer
//   Host-side OScan1 sequencer. Each accepted command becomes a TCKC/TMSC
//   waveform: an Online Activation Code (16 TCKC edges with TMSC high)
//   followed by a 4-bit JScan command, or a run of SF0 scan bits.
//   Each scan bit is sent as TMS then TDI, with zero stuffing on TDI.
//   The TDO bit returned by the target on TMSC is captured for each scan bit.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake from the transport FIFO
//   cmd_op              0=ACTIVATE 1=SCAN 2=DEACTIVATE 3=RAW_JSCAN
//   cmd_len             SCAN bit count (1..MAX_BITS)
//   cmd_tms/cmd_tdi     per-bit TMS/TDI, LSB first
//   cmd_jscan           JScan code for RAW_JSCAN
//   rsp_valid           one-cycle completion pulse
//   rsp_tdo, rsp_err    captured TDO / rejection flag, held until next accept
//   tckc                cJTAG clock to the pad
//   tmsc_out/tmsc_oen   TMSC drive value / drive enable (1 = host drives)
//   tmsc_in             TMSC pad input
//   oscan_on            host's view of the link: 1 = OScan1 SF0 active
//   busy                sequencer not idle
//   dbg_state           current FSM state, for checkers
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is only high in IDLE, so at most one command
// is in flight. All cmd_* fields are captured on that edge, and the host may
// change them afterwards. rsp_valid is a single-cycle pulse with no ready.
// ---------------------------------------------------------------------------
module cjtag_scan_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [5:0]          cmd_len,
  input  logic [MAX_BITS-1:0] cmd_tms,
  input  logic [MAX_BITS-1:0] cmd_tdi,
  input  logic [3:0]          cmd_jscan,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_tdo,
  output logic                rsp_err,
  output logic                tckc,
  output logic                tmsc_out,
  output logic                tmsc_oen,
  input  logic                tmsc_in,
  output logic                oscan_on,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [1:0] OP_ACT   = 2'd0;
  localparam logic [1:0] OP_SCAN  = 2'd1;
  localparam logic [1:0] OP_DEACT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OAC      = 3'd1,
    S_JSCAN    = 3'd2,
    S_SCAN_DRV = 3'd3,
    S_SCAN_TDO = 3'd4,
    S_STUFF    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                r_state, w_next;
  logic [DW-1:0]         r_div;
  logic [4:0]            r_half;     // half-periods elapsed in current state
  logic                  r_tckc, r_out, r_oen, r_oscan, r_live;
  logic [1:0]            r_op;
  logic [5:0]            r_len, r_idx;
  logic [MAX_BITS-1:0]   r_tms, r_tdi, r_tdo;
  logic [3:0]            r_jscan;
  logic [2:0]            r_ones;
  logic                  r_err;

  logic                  w_active, w_tick, w_rise, w_last, w_accept, w_bad;
  logic                  w_scan_done;
  logic [4:0]            w_last_half;
  logic [3:0]            w_code;
  logic [IW-1:0]         w_bit, w_bit_next;
  logic [5:0]            w_idx_next;
  logic [2:0]            w_ones_next;

  assign w_active = (r_state == S_OAC) || (r_state == S_JSCAN) ||
                    (r_state == S_SCAN_DRV) || (r_state == S_SCAN_TDO) ||
                    (r_state == S_STUFF);
  // tckc toggles on the divider wrap; every state ends on a falling edge.
  assign w_tick   = w_active && (r_div == DW'(CLK_DIV - 1));
  assign w_rise   = w_tick && !r_tckc;

  always_comb begin
    w_last_half = 5'd1;
    case (r_state)
      S_OAC:   w_last_half = 5'd15;
      S_JSCAN: w_last_half = 5'd7;
      default: w_last_half = 5'd1;
    endcase
  end

  assign w_last      = w_tick && (r_half == w_last_half);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_bad       = !r_oscan || (cmd_len == 6'd0) || (int'(cmd_len) > MAX_BITS);
  assign w_code      = (r_op == OP_ACT) ? 4'h1 : (r_op == OP_DEACT) ? 4'h0 : r_jscan;
  assign w_bit       = r_idx[IW-1:0];
  assign w_idx_next  = r_idx + 6'd1;
  assign w_bit_next  = w_idx_next[IW-1:0];
  assign w_ones_next = r_tdi[w_bit] ? (r_ones + 3'd1) : 3'd0;
  assign w_scan_done = (w_idx_next == r_len);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept) begin
          if (cmd_op == OP_SCAN) w_next = w_bad ? S_DONE : S_SCAN_DRV;
          else                   w_next = S_OAC;
        end
      S_OAC:      if (w_last) w_next = S_JSCAN;
      S_JSCAN:    if (w_last) w_next = S_DONE;
      S_SCAN_DRV: if (w_last) w_next = (w_ones_next == 3'd5) ? S_STUFF : S_SCAN_TDO;
      S_STUFF:    if (w_last) w_next = S_SCAN_TDO;
      S_SCAN_TDO: if (w_last) w_next = w_scan_done ? S_DONE : S_SCAN_DRV;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (r_state == S_IDLE) && r_live;
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_DONE);
    dbg_state = r_state;
  end

  // Datapath: divider, pad drive, capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_half  <= '0;
      r_tckc  <= 1'b0;
      r_out   <= 1'b0;
      r_oen   <= 1'b0;
      r_oscan <= 1'b0;
      r_live  <= 1'b0;
      r_op    <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_tms   <= '0;
      r_tdi   <= '0;
      r_tdo   <= '0;
      r_jscan <= '0;
      r_ones  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_active) r_div <= w_tick ? '0 : r_div + 1'b1;
      else          r_div <= '0;
      if (w_next != r_state) r_half <= '0;
      else if (w_tick)       r_half <= r_half + 5'd1;
      if (w_tick) r_tckc <= ~r_tckc;

      case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_op    <= cmd_op;
            r_len   <= cmd_len;
            r_tms   <= cmd_tms;
            r_tdi   <= cmd_tdi;
            r_jscan <= cmd_jscan;
            r_tdo   <= '0;
            r_idx   <= '0;
            r_ones  <= '0;
            r_err   <= 1'b0;
            if (cmd_op == OP_SCAN) begin
              if (w_bad) r_err <= 1'b1;
              else begin
                r_out <= cmd_tms[0];
                r_oen <= 1'b1;
              end
            end else begin
              r_out <= 1'b1;   // OAC: TMSC high for 16 edges
              r_oen <= 1'b1;
            end
          end
        S_JSCAN:
          if (w_last) begin
            r_out   <= 1'b0;
            r_oen   <= 1'b0;
            r_oscan <= (r_op == OP_ACT) ||
                       ((r_op != OP_DEACT) && ((r_jscan == 4'h1) || (r_jscan == 4'h4)));
          end else if (w_rise) begin
            // Period index is half-count/2; bit is set up for the falling edge.
            r_out <= w_code[r_half[2:1]];
          end
        S_SCAN_DRV:
          if (w_last) begin
            r_ones <= (w_ones_next == 3'd5) ? 3'd0 : w_ones_next;
            r_out  <= 1'b0;
            r_oen  <= (w_ones_next == 3'd5);   // keep driving for the stuff 0
          end else if (w_rise) begin
            r_out <= r_tdi[w_bit];
          end
        S_STUFF:
          if (w_last) begin
            r_oen  <= 1'b0;
            r_ones <= '0;
          end
        S_SCAN_TDO:
          if (w_last) begin
            r_tdo[w_bit] <= tmsc_in;
            r_idx        <= w_idx_next;
            if (!w_scan_done) begin
              r_out <= r_tms[w_bit_next];
              r_oen <= 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  assign rsp_tdo  = r_tdo;
  assign rsp_err  = r_err;
  assign tckc     = r_tckc;
  assign tmsc_out = r_out;
  assign tmsc_oen = r_oen;
  assign oscan_on = r_oscan;

endmodule

// File: tb/tb_cjtag_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cjtag_scan_sequencer
//   Directed and randomized commands against cjtag_scan_sequencer
//   (CLK_DIV=2, so one TCKC period is 4 clk cycles). A waveform monitor turns
//   the pads into per-period records {oen@rise, tmsc@rise, oen@fall,
//   tmsc@fall}. A target model answers TDO periods. A reference model builds
//   the expected period list, TDO word, error flag, link state and latency
//   from the protocol rules.
// ---------------------------------------------------------------------------
module tb_cjtag_scan_sequencer;
  localparam int CLK_DIV  = 2;
  localparam int MAX_BITS = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = '0;
  logic [5:0]          cmd_len = '0;
  logic [MAX_BITS-1:0] cmd_tms = '0;
  logic [MAX_BITS-1:0] cmd_tdi = '0;
  logic [3:0]          cmd_jscan = '0;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_tdo;
  logic                rsp_err;
  logic                tckc, tmsc_out, tmsc_oen;
  logic                tmsc_in = 1'b0;
  logic                oscan_on, busy;
  logic [2:0]          dbg_state;

  cjtag_scan_sequencer #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
    .cmd_jscan(cmd_jscan), .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo),
    .rsp_err(rsp_err), .tckc(tckc), .tmsc_out(tmsc_out), .tmsc_oen(tmsc_oen),
    .tmsc_in(tmsc_in), .oscan_on(oscan_on), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];   // expected period records
  logic [3:0] msk_q[$];   // which record bits matter
  logic [3:0] obs_q[$];   // observed period records
  logic       tgt_q[$];   // TDO bits the target returns
  bit         model_oscan = 1'b0;
  bit         oen_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- pad monitor + target ----------------
  logic       prev_tckc = 1'b0, prev_out = 1'b0, prev_oen = 1'b0;
  logic [1:0] rise_rec = '0;
  always @(negedge clk) begin
    if (tckc && !prev_tckc) begin
      rise_rec = {prev_oen, prev_out};
      if (!tmsc_oen && tgt_q.size() > 0) tmsc_in = tgt_q.pop_front();
      else                               tmsc_in = 1'($urandom_range(0, 1));
    end
    if (!tckc && prev_tckc) obs_q.push_back({rise_rec, prev_oen, prev_out});
    if (tmsc_oen) oen_seen = 1'b1;
    prev_tckc = tckc;
    prev_out  = tmsc_out;
    prev_oen  = tmsc_oen;
  end

  // ---------------- driver + reference model ----------------
  task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] tms,
                         input logic [31:0] tdi, input logic [3:0] js,
                         input logic [31:0] tgt, input string tag);
    logic        exp_err;
    logic [31:0] exp_tdo;
    logic [3:0]  code;
    int          ones, n, cyc, nper;
    exp_q.delete(); msk_q.delete(); tgt_q.delete();
    exp_tdo = '0;
    exp_err = (op == 2'd1) && (!model_oscan || len == 0 || len > MAX_BITS);
    if (op == 2'd1) begin
      if (!exp_err) begin
        ones = 0;
        for (int b = 0; b < len; b++) begin
          exp_q.push_back({1'b1, tms[b], 1'b1, tdi[b]}); msk_q.push_back(4'hF);
          tgt_q.push_back(tgt[b]);
          exp_tdo[b] = tgt[b];
          ones = tdi[b] ? ones + 1 : 0;
          if (ones == 5) begin
            exp_q.push_back(4'b1010); msk_q.push_back(4'hF);
            ones = 0;
          end
          exp_q.push_back(4'b0000); msk_q.push_back(4'b1010);
        end
      end
    end else begin
      code = (op == 2'd0) ? 4'h1 : (op == 2'd2) ? 4'h0 : js;
      for (int p = 0; p < 8; p++) begin
        exp_q.push_back(4'hF); msk_q.push_back(4'hF);
      end
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({1'b1, (i == 0) ? 1'b1 : code[i-1], 1'b1, code[i]});
        msk_q.push_back(4'hF);
      end
      model_oscan = (op == 2'd0) ? 1'b1 : (op == 2'd2) ? 1'b0 : ((js == 4'h1) || (js == 4'h4));
    end
    nper = exp_q.size();

    cmd_op = op; cmd_len = 6'(len); cmd_tms = tms; cmd_tdi = tdi; cmd_jscan = js;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("%s_accept_lat", tag), n, 0);
    obs_q.delete(); oen_seen = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("%s_tdo_clr", tag), rsp_tdo, 0);
    cyc = 0;
    while (!rsp_valid && cyc < 2000) begin @(negedge clk); cyc++; end
    #1;
    chk($sformatf("%s_cycles", tag), cyc, nper * 2 * CLK_DIV);
    chk($sformatf("%s_err", tag), rsp_err, exp_err);
    chk($sformatf("%s_tdo", tag), rsp_tdo, exp_tdo);
    chk($sformatf("%s_oscan", tag), oscan_on, model_oscan);
    chk($sformatf("%s_tckc_idle", tag), tckc, 0);
    chk($sformatf("%s_nper", tag), obs_q.size(), nper);
    chk($sformatf("%s_oen_seen", tag), oen_seen, (nper > 0));
    for (int i = 0; i < nper && i < obs_q.size(); i++)
      chk($sformatf("%s_wave_p%0d", tag, i), obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
    @(negedge clk);
    chk($sformatf("%s_rsp_pulse", tag), rsp_valid, 0);
    chk($sformatf("%s_ready_after", tag), cmd_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, rv;
    logic [31:0] r_tms, r_tdi;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tdo", rsp_tdo, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_tckc", tckc, 0);
    chk("rst_tmsc_out", tmsc_out, 0);
    chk("rst_oen", tmsc_oen, 0);
    chk("rst_oscan", oscan_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", cmd_ready, 1);

    run_cmd(2'd1, 4, 32'h1, 32'hA, 4'h0, 32'hB, "scan_off");
    run_cmd(2'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, "act");
    run_cmd(2'd1, 4, 32'h1, 32'hA, 4'h0, 32'hB, "scan4");
    run_cmd(2'd1, 7, 32'h0, 32'h7F, 4'h0, $urandom, "scan7_stuff");
    run_cmd(2'd1, 0, $urandom, $urandom, 4'h0, $urandom, "scan_len0");
    run_cmd(2'd1, 33, $urandom, $urandom, 4'h0, $urandom, "scan_len33");
    for (int k = 0; k < 6; k++)
      run_cmd(2'd1, $urandom_range(1, MAX_BITS), $urandom, $urandom | $urandom,
              4'h0, $urandom, $sformatf("rnd%0d", k));
    run_cmd(2'd3, 0, 32'h0, 32'h0, 4'h7, 32'h0, "raw7");
    run_cmd(2'd1, 3, $urandom, $urandom, 4'h0, $urandom, "scan_after_raw7");
    run_cmd(2'd3, 0, 32'h0, 32'h0, 4'h4, 32'h0, "raw4");
    run_cmd(2'd1, $urandom_range(1, MAX_BITS), $urandom, 32'hFFFF_FFFF, 4'h0, $urandom, "scan_ones");
    run_cmd(2'd2, 0, 32'h0, 32'h0, 4'h0, 32'h0, "deact");
    run_cmd(2'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, "act2");

    // Reset while bit 2 is being driven.
    r_tms = $urandom; r_tdi = $urandom;
    tgt_q.delete();
    for (int b = 0; b < 8; b++) tgt_q.push_back(1'($urandom_range(0, 1)));
    cmd_op = 2'd1; cmd_len = 6'd8; cmd_tms = r_tms; cmd_tdi = r_tdi; cmd_valid = 1'b1;
    obs_q.delete();
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (obs_q.size() < 4 && n < 200) begin @(negedge clk); #1; n++; end
    chk("mid_reach_bit2", (obs_q.size() >= 4), 1);
    chk("mid_oen_bit2", tmsc_oen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_tckc", tckc, 0);
    chk("mid_oen", tmsc_oen, 0);
    chk("mid_oscan", oscan_on, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    rst = 1'b0;
    model_oscan = 1'b0;
    tgt_q.delete();
    @(negedge clk);
    chk("mid_ready_after_rel", cmd_ready, 1);
    rv = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) rv++;
      @(negedge clk);
    end
    chk("mid_no_rsp", rv, 0);
    run_cmd(2'd1, 4, 32'h1, 32'hA, 4'h0, 32'hB, "scan_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
